// File: rtl/btn_conditioner.sv
// btn_conditioner
//
// Conditions the raw board push-buttons for the character editor. Each
// channel is synchronised, debounced and turned into a clean level, one-cycle
// press/release pulses and an "action" pulse that auto-repeats while the
// button is held (only on channels enabled in REPEAT_MASK).
//
// Ports:
//   clk_pin      system clock
//   rst          synchronous, active-high reset
//   btn_raw      asynchronous raw button levels, 1 = pressed
//   btn_level    debounced level
//   btn_press    1-cycle pulse when the debounced level rises
//   btn_release  1-cycle pulse when the debounced level falls
//   btn_repeat   1-cycle pulse on press, then periodic pulses while held
//   btn_busy     OR of btn_level
module btn_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_PERIOD   = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01010
) (
    input  logic             clk_pin,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             btn_busy
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = (RC_MAX > 2) ? $clog2(RC_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic             s1;
        logic             s2;
        logic             stable;
        logic [CNT_W-1:0] cnt;
        logic             press_q;
        logic             release_q;
        logic             rise;
        logic             fall;

        // The stable state flips on exactly the edge where the counter
        // expires; these flag that edge so the pulses land in the same cycle
        // as the level change.
        always_comb begin
            rise = s2 & ~stable & (cnt == CNT_LAST);
            fall = ~s2 & stable & (cnt == CNT_LAST);
        end

        // Two-flop synchroniser followed by the debounce counter. Any sample
        // that agrees with the stable state restarts the count.
        always_ff @(posedge clk_pin) begin
            if (rst) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                stable    <= 1'b0;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1        <= btn_raw[i];
                s2        <= s1;
                press_q   <= rise;
                release_q <= fall;
                if (s2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign btn_level[i]   = stable;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

        if (REPEAT_MASK[i]) begin : g_rep
            rep_state_t      state;
            rep_state_t      state_next;
            logic [RC_W-1:0] rc;
            logic [RC_W-1:0] rc_next;
            logic            pulse;
            logic            repeat_q;
            logic            level_next;

            // Level the debouncer will hold after this edge. Looking ahead
            // lets a release on the same edge as a due repeat suppress it.
            assign level_next = rise | (stable & ~fall);

            // Repeat FSM state, its counter and the registered pulse.
            always_ff @(posedge clk_pin) begin
                if (rst) begin
                    state    <= IDLE;
                    rc       <= '0;
                    repeat_q <= 1'b0;
                end else begin
                    state    <= state_next;
                    rc       <= rc_next;
                    repeat_q <= pulse;
                end
            end

            // Next state: initial delay in HOLD, then fixed period in REPEAT.
            always_comb begin
                state_next = state;
                rc_next    = rc;
                if (!level_next) begin
                    state_next = IDLE;
                    rc_next    = '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise) begin
                                state_next = HOLD;
                                rc_next    = '0;
                            end
                        end
                        HOLD: begin
                            if (rc == DELAY_LAST) begin
                                state_next = REPEAT;
                                rc_next    = '0;
                            end else begin
                                rc_next = rc + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rc == PERIOD_LAST) begin
                                rc_next = '0;
                            end else begin
                                rc_next = rc + 1'b1;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            rc_next    = '0;
                        end
                    endcase
                end
            end

            // Pulse decision, registered above so it aligns with btn_press.
            always_comb begin
                pulse = 1'b0;
                if (level_next) begin
                    case (state)
                        IDLE:    pulse = rise;
                        HOLD:    pulse = (rc == DELAY_LAST);
                        REPEAT:  pulse = (rc == PERIOD_LAST);
                        default: pulse = 1'b0;
                    endcase
                end
            end

            assign btn_repeat[i] = repeat_q;
        end else begin : g_norep
            assign btn_repeat[i] = press_q;
        end
    end

    assign btn_busy = |btn_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//
// Scoreboard bench for btn_conditioner with short debounce/repeat timings.
// Stimulus pushes hand-computed pulse events (cycle plus full output vectors)
// into a queue; a monitor pops and compares whenever any pulse appears.
module tb_btn_conditioner;

    localparam int N   = 5;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic         clk_pin = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic         btn_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
        logic [N-1:0] lvl;
    } exp_t;

    exp_t sb[$];

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER),
        .REPEAT_MASK    (5'b01010)
    ) dut (
        .clk_pin    (clk_pin),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_busy   (btn_busy)
    );

    always #5 clk_pin = ~clk_pin;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    always @(posedge clk_pin) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [N-1:0] actual,
                               input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_level"}, btn_level, '0);
        checkOutput({name, "_press"}, btn_press, '0);
        checkOutput({name, "_release"}, btn_release, '0);
        checkOutput({name, "_repeat"}, btn_repeat, '0);
        checkOutput({name, "_busy"}, {4'b0, btn_busy}, '0);
    endtask

    task automatic applyStimulus(input logic [N-1:0] raw);
        btn_raw = raw;
    endtask

    task automatic expectAt(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                            input logic [N-1:0] rp, input logic [N-1:0] l);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.rpt   = rp;
        e.lvl   = l;
        sb.push_back(e);
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk_pin);
    endtask

    // Monitor: overdue expectations are misses; every pulse must match the
    // head of the scoreboard at exactly the expected cycle.
    always @(negedge clk_pin) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missed_event: got no pulse at cycle %0d, expected press=%b rel=%b rpt=%b",
                         sb[0].cyc, sb[0].press, sb[0].rel, sb[0].rpt);
                void'(sb.pop_front());
            end
            if ((btn_press | btn_release | btn_repeat) != '0) begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("ev_press", btn_press, e.press);
                    checkOutput("ev_release", btn_release, e.rel);
                    checkOutput("ev_repeat", btn_repeat, e.rpt);
                    checkOutput("ev_level", btn_level, e.lvl);
                    checkOutput("ev_busy", {4'b0, btn_busy}, {4'b0, |e.lvl});
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse at cycle %0d: got press=%b rel=%b rpt=%b, expected none",
                             cyc, btn_press, btn_release, btn_repeat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int b;
        int p;
        int q;

        // Scenario 1: reset for 3 edges, then idle.
        rst = 1'b1;
        applyStimulus('0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pin);
            checkAllZero("reset");
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_pin);
            checkAllZero("idle");
        end

        // Scenario 2: clean press/release on btn[0] (unmasked).
        b = cyc;
        applyStimulus(5'b00001);
        expectAt(b + 6, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
        expectAt(b + 26, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
        waitUntil(b + 5);
        checkOutput("b0_level_early", btn_level, 5'b00000);
        waitUntil(b + 6);
        checkOutput("b0_level_up", btn_level, 5'b00001);
        checkOutput("b0_busy_up", {4'b0, btn_busy}, 5'b00001);
        waitUntil(b + 20);
        applyStimulus(5'b00000);
        waitUntil(b + 25);
        checkOutput("b0_level_held", btn_level, 5'b00001);
        waitUntil(b + 26);
        checkOutput("b0_level_down", btn_level, 5'b00000);
        checkOutput("b0_busy_down", {4'b0, btn_busy}, 5'b00000);
        waitUntil(b + 34);

        // Scenarios 3 and 4: bounce on btn[1], then hold for auto-repeat.
        b = cyc;
        p = b + 14;
        expectAt(p, 5'b00010, 5'b00000, 5'b00010, 5'b00010);
        for (int k = 10; k <= 34; k += 3)
            expectAt(p + k, 5'b00000, 5'b00000, 5'b00010, 5'b00010);
        expectAt(p + 36, 5'b00000, 5'b00010, 5'b00000, 5'b00000);
        applyStimulus(5'b00010);
        waitUntil(b + 2);
        applyStimulus(5'b00000);
        waitUntil(b + 4);
        applyStimulus(5'b00010);
        waitUntil(b + 6);
        applyStimulus(5'b00000);
        waitUntil(b + 8);
        applyStimulus(5'b00010);
        waitUntil(p - 1);
        checkOutput("b1_bounce_level", btn_level, 5'b00000);
        waitUntil(p + 30);
        applyStimulus(5'b00000);
        waitUntil(p + 46);

        // Scenario 5: btn[1] and btn[3] together; btn[1] released on a due repeat.
        b = cyc;
        p = b + 6;
        expectAt(p, 5'b01010, 5'b00000, 5'b01010, 5'b01010);
        expectAt(p + 10, 5'b00000, 5'b00000, 5'b01010, 5'b01010);
        expectAt(p + 13, 5'b00000, 5'b00000, 5'b01010, 5'b01010);
        expectAt(p + 16, 5'b00000, 5'b00010, 5'b01000, 5'b01000);
        expectAt(p + 19, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(p + 22, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(p + 25, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(p + 26, 5'b00000, 5'b01000, 5'b00000, 5'b00000);
        applyStimulus(5'b01010);
        waitUntil(p + 10);
        applyStimulus(5'b01000);
        waitUntil(p + 20);
        applyStimulus(5'b00000);
        waitUntil(p + 34);

        // Scenario 6: reset mid-repeat on btn[3] with the button still held.
        b = cyc;
        p = b + 6;
        q = p + 21;
        expectAt(p, 5'b01000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(p + 10, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(p + 13, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(q, 5'b01000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(q + 10, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(q + 13, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(q + 16, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(q + 19, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
        expectAt(q + 20, 5'b00000, 5'b01000, 5'b00000, 5'b00000);
        applyStimulus(5'b01000);
        waitUntil(p + 14);
        rst = 1'b1;
        waitUntil(p + 15);
        checkAllZero("midreset");
        rst = 1'b0;
        waitUntil(q - 1);
        checkOutput("b3_level_rearm", btn_level, 5'b00000);
        waitUntil(q + 14);
        applyStimulus(5'b00000);
        waitUntil(q + 30);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
